// File: rtl/seg_display_scheduler.sv
// Arbitrates the 4-digit 7-seg display between the game (blink + leading-zero blanking)
// and a timed message source. Optional macro MSG_ABORT_EN adds msg_abort_i for early release.
module seg_display_scheduler #(
  parameter int HOLD_MS       = 2000,
  parameter int BLINK_HALF_MS = 250
) (
  input  logic        clk_1k_i,
  input  logic        rst,
  input  logic [15:0] game_digits_i,
  input  logic [3:0]  game_en_i,
  input  logic [3:0]  blink_mask_i,
  input  logic        lz_suppress_i,
  input  logic        msg_valid_i,
  output logic        msg_ready_o,
  input  logic [15:0] msg_digits_i,
  input  logic [3:0]  msg_en_i,
`ifdef MSG_ABORT_EN
  input  logic        msg_abort_i,
`endif
  output logic [15:0] digit_o,
  output logic [3:0]  digit_en_o,
  output logic        showing_msg_o,
  output logic        msg_done_o,
  output logic        state_dbg_o
);

  localparam int HW = $clog2(HOLD_MS + 1);
  localparam int BW = $clog2(BLINK_HALF_MS + 1);

  typedef enum logic {S_GAME = 1'b0, S_MSG = 1'b1} state_e;

  // Handshake: a message is taken on any clk_1k_i edge where msg_valid_i && msg_ready_o;
  // the requester keeps msg_valid_i and its data stable until that edge.
  state_e          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [15:0]     msg_dig_q;
  logic [3:0]      msg_en_q;
  logic [BW-1:0]   blink_cnt_q;
  logic            blink_on_q;
  logic [15:0]     digit_q, digit_d;
  logic [3:0]      digit_en_q, digit_en_d;
  logic            showing_q, showing_d;
  logic            abort_w, accept, hold_end;
  logic [3:0]      lz_blank;

`ifdef MSG_ABORT_EN
  assign abort_w = msg_abort_i;
`else
  assign abort_w = 1'b0;
`endif

  assign accept   = msg_valid_i & msg_ready_o;
  assign hold_end = (state_q == S_MSG) && ((hold_q == '0) || abort_w);

  always_ff @(posedge clk_1k_i) begin
    if (!rst) begin
      state_q   <= S_GAME;
      hold_q    <= '0;
      msg_dig_q <= '0;
      msg_en_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (accept) begin
        msg_dig_q <= msg_digits_i;
        msg_en_q  <= msg_en_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_GAME: begin
        if (accept) begin
          state_d = S_MSG;
          hold_d  = HW'(HOLD_MS - 1);
        end
      end
      S_MSG: begin
        if (hold_end) begin
          state_d = S_GAME;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: state_d = S_GAME;
    endcase
  end

  // Digit 0 is never blanked so an all-zero value still shows a single "0".
  always_comb begin
    msg_ready_o = rst && (state_q == S_GAME);
    msg_done_o  = rst && hold_end;
    state_dbg_o = (state_q == S_MSG);
    lz_blank[3] = lz_suppress_i && (game_digits_i[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (game_digits_i[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (game_digits_i[7:4] == 4'h0);
    lz_blank[0] = 1'b0;
    if (state_q == S_MSG) begin
      digit_d    = msg_dig_q;
      digit_en_d = msg_en_q;
      showing_d  = 1'b1;
    end else begin
      digit_d    = game_digits_i;
      digit_en_d = game_en_i & ~(blink_mask_i & {4{~blink_on_q}}) & ~lz_blank;
      showing_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_1k_i) begin
    if (!rst) begin
      digit_q    <= '0;
      digit_en_q <= '0;
      showing_q  <= 1'b0;
    end else begin
      digit_q    <= digit_d;
      digit_en_q <= digit_en_d;
      showing_q  <= showing_d;
    end
  end

  // Blink timebase free-runs in both states so game blinking stays in phase across messages.
  always_ff @(posedge clk_1k_i) begin
    if (!rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_HALF_MS - 1)) begin
      blink_cnt_q <= '0;
      blink_on_q  <= ~blink_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BW'(1);
    end
  end

  assign digit_o       = digit_q;
  assign digit_en_o    = digit_en_q;
  assign showing_msg_o = showing_q;

endmodule
